sprite_layer_renderer: RTL and testbench
========================================

# sprite_layer_renderer

Pipelined, parametrised sprite layer for the VGA color path. Holds position, enable and animation-frame state for `NUM_SPRITES` sprites and hit-tests each incoming `DrawX`/`DrawY` pixel against them. It generates the sprite-ROM address for the highest-priority hit and returns RGB888 with transparency keying. It sits between the VGA scan counter and the final color mux, replacing the single-ball, fixed-128-wide sprite path with multi-sprite, multi-frame rendering and tear-free updates.

## Interface
- `NUM_SPRITES`, 4, sprite slots; index 0 has highest priority
- `SPR_W`, 128, sprite width in pixels
- `SPR_H`, 208, sprite height in pixels
- `FRAMES`, 4, animation frames per sprite image in ROM
- `ADDR_W`, 17, ROM address width; must satisfy FRAMES·SPR_W·SPR_H ≤ 2^ADDR_W
- `TRANSPARENT_KEY`, 24'hFF00FF, ROM color treated as transparent
- `BG_COLOR`, 24'h000000, color output when no opaque sprite pixel
- `clk`  in  1  system clock; one clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `DrawX`  in  10  current pixel column
- `DrawY`  in  10  current pixel row
- `pix_valid`  in  1  DrawX/DrawY is an active-video pixel this cycle
- `frame_commit`  in  1  one-cycle pulse at vertical blank; shadow registers → active
- `wr_en`  in  1  write one sprite slot's shadow registers
- `wr_idx`  in  $clog2(NUM_SPRITES)  slot written
- `wr_x`, `wr_y`  in  10 each  sprite top-left corner
- `wr_frame`  in  $clog2(FRAMES)  animation frame select
- `wr_enable`  in  1  sprite visible
- `wr_flip`  in  1  horizontal mirror (present only with SPRITE_MIRROR_EN)
- `rom_addr`  out  ADDR_W  address to external synchronous sprite ROM (1-cycle read latency)
- `rom_data`  in  24  ROM word {R,G,B}
- `Red`, `Green`, `Blue`  out  8 each  output color
- `hit`  out  1  output pixel is an opaque sprite pixel
- `out_valid`  out  1  pipelined copy of pix_valid

## Operation
- Register banks: a shadow bank and an active bank per slot, each holding {x, y, frame, enable[, flip]}. `wr_en` writes the shadow bank only. `frame_commit` copies all shadow slots to active in one cycle. Hit-testing uses the active bank only, so no mid-frame tearing.
- Same-cycle `wr_en` and `frame_commit`: the committed value includes that cycle's write.
- `wr_idx` ≥ NUM_SPRITES: write ignored.
- Hit test per slot, 11-bit unsigned: enable && DrawX ≥ x && DrawX < x+SPR_W && DrawY ≥ y && DrawY < y+SPR_H. Sprites overhanging the right or bottom edge clip; there is no wrap-around.
- Priority: lowest-index hitting slot wins. Transparency does not fall through to lower-priority slots.
- dx = DrawX−x, dy = DrawY−y. Address = frame·SPR_W·SPR_H + dy·SPR_W + dx, computed at ADDR_W bits.
- No hit: rom_addr holds its previous value, and the pixel is marked miss.
- Stage 3: if pix_valid=0, output RGB=0 and hit=0. Else if miss or rom_data==TRANSPARENT_KEY, output BG_COLOR and hit=0. Else output rom_data and hit=1.

## Timing
- Stage 1 (edge E0): registers hit flag, pix_valid, rom_addr. rom_addr is valid in cycle n+1 for a pixel presented in cycle n.
- ROM registers the address at E1; rom_data is valid in cycle n+2.
- Stage 3 (edge E2): registers Red/Green/Blue/hit/out_valid, valid in cycle n+3. Fixed latency 3 with throughput 1 pixel/clk and no stalls.
- A commit at edge E affects pixels presented from the cycle after E. Pixels already in flight are unaffected.
- Reset values: all active and shadow slots cleared (enable=0, x=y=frame=0, flip=0). rom_addr=0, Red=Green=Blue=0, hit=0, out_valid=0. All stage registers are flushed.
- Reset asserted mid-line: outputs read 0 starting the cycle after reset. out_valid stays 0 until 3 cycles after the first pix_valid following reset release.

## Configuration
- `SPRITE_MIRROR_EN` defined: `wr_flip` port and a per-slot flip bit exist. When flip=1, the address uses dx' = SPR_W−1−dx.
- Undefined: no `wr_flip` port and no flip storage. dx is always used.

## Test plan
- Reset, then sweep DrawX 0..127 and DrawY 0..207 with pix_valid=1 and no sprites enabled -> all outputs BG_COLOR with hit=0. out_valid follows pix_valid with 3-cycle delay.
- Write slot 0 {x=0,y=0,frame=0,en=1}, commit, sweep the full 128×208 -> rom_addr steps 0..26623 in raster order, 1 cycle after each pixel. RGB equals the ROM model's contents, 3 cycles after each pixel.
- Slot 0 at x=600 (partly off-screen) and frame=2 -> pixel (600,0) gives rom_addr=53248. DrawX=639 gives 53287. DrawX<600 gives a miss.
- Slots 0 and 1 overlap at (10,10), with the ROM word for slot 0 = FF00FF -> output BG_COLOR, hit=0, with no fall-through to slot 1. Swap the ROM data to non-key -> output the slot 0 color.
- Write slot 1 x=50 mid-frame without a commit -> rendering still uses the old x. Pulse frame_commit together with wr_en to x=60 -> the next pixel uses x=60.
- With SPRITE_MIRROR_EN and flip=1, pixel dx=0 -> rom_addr=127. Assert reset mid-sweep -> next cycle all outputs 0 and all slots disabled.

Source files
------------

// File: rtl/sprite_layer_renderer.sv
// Multi-sprite layer for the VGA colour path: shadow/active slot banks, priority hit test,
// ROM address generation and transparency keying. `SPRITE_MIRROR_EN adds per-slot horizontal flip.
module sprite_layer_renderer #(
  parameter int          NUM_SPRITES     = 4,
  parameter int          SPR_W           = 128,
  parameter int          SPR_H           = 208,
  parameter int          FRAMES          = 4,
  parameter int          ADDR_W          = 17,
  parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF,
  parameter logic [23:0] BG_COLOR        = 24'h000000,
  localparam int         IDX_W           = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int         FRM_W           = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic              frame_commit,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [FRM_W-1:0]  wr_frame,
  input  logic              wr_enable,
`ifdef SPRITE_MIRROR_EN
  input  logic              wr_flip,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              hit,
  output logic              out_valid
);

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [FRM_W-1:0] frame;
    logic             en;
`ifdef SPRITE_MIRROR_EN
    logic             flip;
`endif
  } slot_t;

  slot_t shadow_q [NUM_SPRITES];
  slot_t shadow_d [NUM_SPRITES];
  slot_t active_q [NUM_SPRITES];
  slot_t active_d [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] slot_hit;
  logic [10:0]            dx_all [NUM_SPRITES];
  logic [10:0]            dy_all [NUM_SPRITES];
  logic                   any_hit;
  logic [IDX_W-1:0]       sel_idx;
  logic [10:0]            sel_dx;
  logic [ADDR_W-1:0]      addr_calc;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_hit_q, s1_hit_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_hit_q, s2_hit_d;
  logic [7:0]        red_q, red_d;
  logic [7:0]        green_q, green_d;
  logic [7:0]        blue_q, blue_d;
  logic              hit_q, hit_d;
  logic              out_valid_q, out_valid_d;

  // The commit sees this cycle's write because it copies the already-merged shadow_d.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && (int'(wr_idx) < NUM_SPRITES)) begin
      shadow_d[wr_idx].x     = wr_x;
      shadow_d[wr_idx].y     = wr_y;
      shadow_d[wr_idx].frame = wr_frame;
      shadow_d[wr_idx].en    = wr_enable;
`ifdef SPRITE_MIRROR_EN
      shadow_d[wr_idx].flip  = wr_flip;
`endif
    end
    if (frame_commit) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  // 11-bit compares so sprites overhanging the right/bottom edge clip instead of wrapping.
  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx_all[i]   = {1'b0, DrawX} - {1'b0, active_q[i].x};
      dy_all[i]   = {1'b0, DrawY} - {1'b0, active_q[i].y};
      slot_hit[i] = active_q[i].en &&
                    ({1'b0, DrawX} >= {1'b0, active_q[i].x}) &&
                    ({1'b0, DrawX} <  ({1'b0, active_q[i].x} + 11'(SPR_W))) &&
                    ({1'b0, DrawY} >= {1'b0, active_q[i].y}) &&
                    ({1'b0, DrawY} <  ({1'b0, active_q[i].y} + 11'(SPR_H)));
    end
  end

  always_comb begin
    any_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        any_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_dx = dx_all[sel_idx];
`ifdef SPRITE_MIRROR_EN
    if (active_q[sel_idx].flip) begin
      sel_dx = 11'(SPR_W - 1) - dx_all[sel_idx];
    end
`endif
    addr_calc = ADDR_W'(active_q[sel_idx].frame) * ADDR_W'(SPR_W * SPR_H) +
                ADDR_W'(dy_all[sel_idx]) * ADDR_W'(SPR_W) +
                ADDR_W'(sel_dx);
  end

  always_comb begin
    s1_valid_d  = pix_valid;
    s1_hit_d    = any_hit;
    rom_addr_d  = any_hit ? addr_calc : rom_addr_q;
    s2_valid_d  = s1_valid_q;
    s2_hit_d    = s1_hit_q;
    out_valid_d = s2_valid_q;
    red_d       = 8'd0;
    green_d     = 8'd0;
    blue_d      = 8'd0;
    hit_d       = 1'b0;
    if (s2_valid_q) begin
      if (!s2_hit_q || (rom_data == TRANSPARENT_KEY)) begin
        {red_d, green_d, blue_d} = BG_COLOR;
      end else begin
        {red_d, green_d, blue_d} = rom_data;
        hit_d                    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      rom_addr_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_hit_q    <= 1'b0;
      red_q       <= 8'd0;
      green_q     <= 8'd0;
      blue_q      <= 8'd0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      rom_addr_q  <= rom_addr_d;
      s2_valid_q  <= s2_valid_d;
      s2_hit_q    <= s2_hit_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hit_q       <= hit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign Red       = red_q;
  assign Green     = green_q;
  assign Blue      = blue_q;
  assign hit       = hit_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Scoreboard bench for sprite_layer_renderer: a behavioural slot model predicts rom_addr (1 cycle)
// and colour/hit/out_valid (3 cycles); a synchronous ROM model answers rom_addr.
module tb_sprite_layer_renderer;
  localparam int NS = 4;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [23:0] BG  = 24'h000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        pix_valid = 1'b0, frame_commit = 1'b0, wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [9:0]  wr_x = '0, wr_y = '0;
  logic [1:0]  wr_frame = '0;
  logic        wr_enable = 1'b0;
`ifdef SPRITE_MIRROR_EN
  logic        wr_flip = 1'b0;
`endif
  logic [16:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [7:0]  Red, Green, Blue;
  logic        hit, out_valid;

  always #5 clk = ~clk;

  sprite_layer_renderer dut (
    .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
    .frame_commit(frame_commit), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_frame(wr_frame), .wr_enable(wr_enable),
`ifdef SPRITE_MIRROR_EN
    .wr_flip(wr_flip),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .Red(Red), .Green(Green), .Blue(Blue),
    .hit(hit), .out_valid(out_valid)
  );

  int checks = 0, errors = 0, cyc = 0;
  bit key_on = 1'b0;
  logic [16:0] key_addr = '0;

  int sh_x[NS], sh_y[NS], sh_fr[NS], ac_x[NS], ac_y[NS], ac_fr[NS];
  bit sh_en[NS], sh_fl[NS], ac_en[NS], ac_fl[NS];
  logic [16:0] last_addr = '0;

  typedef struct { int due; logic [16:0] addr; } addr_e_t;
  typedef struct { int due; bit v; bit h; logic [23:0] rgb; } out_e_t;
  addr_e_t addr_q[$];
  out_e_t  out_q[$];

  function automatic logic [23:0] rom_word(input logic [16:0] a);
    logic [23:0] w;
    w = {a[7:0] ^ 8'h3C, a[16:9], a[8:1] + 8'd7};
    if (key_on && a == key_addr) w = KEY;
    else if (w == KEY) w = 24'hFF00FE;
    return w;
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  function automatic void ref_pix(input int px, input int py, output bit h, output logic [16:0] a);
    int dx;
    h = 1'b0;
    a = '0;
    for (int i = 0; i < NS; i++) begin
      if (!h && ac_en[i] && px >= ac_x[i] && px < ac_x[i] + 128 && py >= ac_y[i] && py < ac_y[i] + 208) begin
        h  = 1'b1;
        dx = px - ac_x[i];
        if (ac_fl[i]) dx = 127 - dx;
        a  = 17'(ac_fr[i] * 26624 + (py - ac_y[i]) * 128 + dx);
      end
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_fr[i] = 0; sh_en[i] = 0; sh_fl[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_fr[i] = 0; ac_en[i] = 0; ac_fl[i] = 0;
    end
    last_addr = '0;
  endtask

  // Advance one clock and retire every scoreboard entry that is due now.
  task automatic tick();
    addr_e_t ae;
    out_e_t  oe;
    @(posedge clk);
    #1;
    cyc++;
    while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
      ae = addr_q.pop_front();
      checks++;
      if (rom_addr !== ae.addr) begin
        errors++;
        $display("FAIL sb_rom_addr cyc %0d got %0d exp %0d", cyc, rom_addr, ae.addr);
      end
    end
    while (out_q.size() > 0 && out_q[0].due == cyc) begin
      oe = out_q.pop_front();
      checks++;
      if ({out_valid, hit, Red, Green, Blue} !== {oe.v, oe.h, oe.rgb}) begin
        errors++;
        $display("FAIL sb_pixel cyc %0d got v=%0b h=%0b rgb=%06h exp v=%0b h=%0b rgb=%06h",
                 cyc, out_valid, hit, {Red, Green, Blue}, oe.v, oe.h, oe.rgb);
      end
    end
  endtask

  // Present one pixel; any wr_en/frame_commit already set by the caller takes effect at this edge.
  task automatic step(input int px, input int py, input bit v);
    bit h;
    logic [16:0] a;
    logic [23:0] w;
    out_e_t oe;
    DrawX = 10'(px); DrawY = 10'(py); pix_valid = v;
    ref_pix(px, py, h, a);
    if (h) last_addr = a;
    addr_q.push_back('{cyc + 1, last_addr});
    oe = '{cyc + 3, v, 1'b0, 24'h0};
    if (v) begin
      oe.rgb = BG;
      if (h) begin
        w = rom_word(a);
        if (w != KEY) begin oe.h = 1'b1; oe.rgb = w; end
      end
    end
    out_q.push_back(oe);
    if (wr_en && int'(wr_idx) < NS) begin
      sh_x[wr_idx] = wr_x; sh_y[wr_idx] = wr_y; sh_fr[wr_idx] = wr_frame; sh_en[wr_idx] = wr_enable;
`ifdef SPRITE_MIRROR_EN
      sh_fl[wr_idx] = wr_flip;
`endif
    end
    if (frame_commit) begin
      ac_x = sh_x; ac_y = sh_y; ac_fr = sh_fr; ac_en = sh_en; ac_fl = sh_fl;
    end
    tick();
    wr_en = 1'b0; frame_commit = 1'b0;
  endtask

  task automatic set_wr(input int idx, input int x, input int y, input int fr, input bit en, input bit fl);
    wr_en = 1'b1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_frame = 2'(fr); wr_enable = en;
`ifdef SPRITE_MIRROR_EN
    wr_flip = fl;
`else
    if (fl) $display("note: flip requested without mirror support");
`endif
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input int fr, input bit en, input bit commit);
    set_wr(idx, x, y, fr, en, 1'b0);
    frame_commit = commit;
    step(0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(0, 0, 1'b0);
  endtask

  task automatic test_reset();
    addr_q.delete(); out_q.delete();
    reset = 1'b1; pix_valid = 1'b1;
    tick(); tick();
    reset = 1'b0; pix_valid = 1'b0;
    clear_model();
    checks++;
    if ({Red, Green, Blue} !== 24'h0 || hit !== 1'b0) begin
      errors++; $display("FAIL reset_color got rgb=%06h hit=%0b exp 0", {Red, Green, Blue}, hit);
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++;
    if (rom_addr !== 17'd0) begin errors++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); end
  endtask

  task automatic test_no_sprites();
    for (int y = 0; y < 208; y++)
      for (int x = 0; x < 128; x++) step(x, y, 1'b1);
    drain();
  endtask

  task automatic test_full_sprite();
    write_slot(0, 0, 0, 0, 1'b1, 1'b1);
    for (int y = 0; y < 208; y++)
      for (int x = 0; x < 128; x++) step(x, y, 1'b1);
    checks++;
    if (rom_addr !== 17'd26623) begin errors++; $display("FAIL full_last_addr got %0d exp 26623", rom_addr); end
    drain();
  endtask

  task automatic test_offscreen();
    write_slot(0, 600, 0, 2, 1'b1, 1'b1);
    step(600, 0, 1'b1);
    checks++;
    if (rom_addr !== 17'd53248) begin errors++; $display("FAIL off_left got %0d exp 53248", rom_addr); end
    step(639, 0, 1'b1);
    checks++;
    if (rom_addr !== 17'd53287) begin errors++; $display("FAIL off_right got %0d exp 53287", rom_addr); end
    step(599, 0, 1'b1);
    checks++;
    if (rom_addr !== 17'd53287) begin errors++; $display("FAIL off_miss_hold got %0d exp 53287", rom_addr); end
    step(0, 0, 1'b1);
    step(700, 207, 1'b1);
    step(700, 208, 1'b1);
    drain();
  endtask

  task automatic test_priority_key();
    write_slot(0, 10, 10, 0, 1'b1, 1'b0);
    write_slot(1, 5, 5, 1, 1'b1, 1'b1);
    drain();
    key_addr = 17'd0; key_on = 1'b1;
    step(10, 10, 1'b1); step(0, 0, 1'b0); step(0, 0, 1'b0);
    checks++;
    if (hit !== 1'b0 || {Red, Green, Blue} !== BG) begin
      errors++; $display("FAIL key_no_fallthrough got hit=%0b rgb=%06h exp hit=0 rgb=%06h", hit, {Red, Green, Blue}, BG);
    end
    drain();
    key_on = 1'b0;
    step(10, 10, 1'b1); step(0, 0, 1'b0); step(0, 0, 1'b0);
    checks++;
    if (hit !== 1'b1 || {Red, Green, Blue} !== 24'h3C0007) begin
      errors++; $display("FAIL slot0_color got hit=%0b rgb=%06h exp hit=1 rgb=3c0007", hit, {Red, Green, Blue});
    end
    step(6, 6, 1'b1);
    drain();
  endtask

  task automatic test_shadow();
    write_slot(0, 10, 10, 0, 1'b0, 1'b1);
    set_wr(1, 50, 5, 1, 1'b1, 1'b0);
    step(5, 5, 1'b1);
    checks++;
    if (rom_addr !== 17'd26624) begin errors++; $display("FAIL shadow_old_x got %0d exp 26624", rom_addr); end
    step(52, 5, 1'b1);
    set_wr(1, 60, 5, 1, 1'b1, 1'b0);
    frame_commit = 1'b1;
    step(5, 5, 1'b1);
    step(61, 6, 1'b1);
    checks++;
    if (rom_addr !== 17'd26753) begin errors++; $display("FAIL commit_new_x got %0d exp 26753", rom_addr); end
    step(5, 5, 1'b1);
    drain();
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror();
    set_wr(1, 60, 5, 0, 1'b1, 1'b1);
    frame_commit = 1'b1;
    step(0, 0, 1'b0);
    step(60, 5, 1'b1);
    checks++;
    if (rom_addr !== 17'd127) begin errors++; $display("FAIL mirror_dx0 got %0d exp 127", rom_addr); end
    step(187, 6, 1'b1);
    drain();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < NS; i++)
      write_slot(i, $urandom_range(700), $urandom_range(400), $urandom_range(3), 1'(($urandom_range(3)) != 0), i == NS - 1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(40) == 0) set_wr($urandom_range(3), $urandom_range(700), $urandom_range(400), $urandom_range(3), 1'b1, 1'b0);
      if ($urandom_range(60) == 0) frame_commit = 1'b1;
      step($urandom_range(900), $urandom_range(600), 1'($urandom_range(5) != 0));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    write_slot(0, 0, 0, 1, 1'b1, 1'b1);
    for (int x = 0; x < 20; x++) step(x, 3, 1'b1);
    addr_q.delete(); out_q.delete();
    reset = 1'b1; DrawX = 10'd21; DrawY = 10'd3; pix_valid = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    checks++;
    if ({out_valid, hit, Red, Green, Blue, rom_addr} !== '0) begin
      errors++; $display("FAIL reset_mid got v=%0b h=%0b rgb=%06h addr=%0d exp all 0",
                         out_valid, hit, {Red, Green, Blue}, rom_addr);
    end
    pix_valid = 1'b0;
    step(0, 0, 1'b0); step(0, 0, 1'b0);
    for (int x = 0; x < 16; x++) step(x, 3, 1'b1);
    drain();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_no_sprites();
    test_full_sprite();
    test_offscreen();
    test_priority_key();
    test_shadow();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
